// File: rtl/run_monitor_pkg.sv
// Shared types for the end-of-run monitor: controller states, the report record
// layout and the saturation constant used by every counter.
package run_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Record fields are sized for the widest supported build and sliced at the top.
  localparam int REC_ID_W  = 16;
  localparam int REC_CNT_W = 64;

  localparam logic [REC_CNT_W-1:0] COUNTER_MAX = {REC_CNT_W{1'b1}};

  typedef struct packed {
    logic [REC_ID_W-1:0]  core;
    logic                 done;
    logic [REC_CNT_W-1:0] cycles;
    logic [REC_CNT_W-1:0] instret;
  } report_rec_t;

endpackage

// File: rtl/run_monitor_core_tracker.sv
// Per-core tracker: stop-address compare, sticky done flag, stop timestamp and a
// saturating retired-instruction counter. Everything freezes once done is set.
module run_monitor_core_tracker
  import run_monitor_pkg::*;
#(
  parameter int ADDRESS_BITS  = 12,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     enable,
  input  logic [ADDRESS_BITS-1:0]  pc,
  input  logic                     pc_valid,
  input  logic [ADDRESS_BITS-1:0]  stop_addr,
  input  logic [COUNTER_WIDTH-1:0] cycle_count,
  output logic                     match,
  output logic                     done,
  output logic [COUNTER_WIDTH-1:0] stamp,
  output logic [COUNTER_WIDTH-1:0] instret
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = COUNTER_MAX[COUNTER_WIDTH-1:0];

  logic                     done_r;
  logic [COUNTER_WIDTH-1:0] stamp_r;
  logic [COUNTER_WIDTH-1:0] instret_r;
  logic                     track_s;
  logic                     match_s;

  // Bubbles never match, so a stale PC parked on stop_addr is harmless.
  always_comb begin
    track_s = enable & pc_valid & ~done_r;
    match_s = track_s & (pc == stop_addr);
  end

  // Tracking registers; the stop instruction itself is counted as retired.
  always_ff @(posedge clock) begin
    if (!reset) begin
      done_r    <= 1'b0;
      stamp_r   <= '0;
      instret_r <= '0;
    end else if (clear) begin
      done_r    <= 1'b0;
      stamp_r   <= '0;
      instret_r <= '0;
    end else if (track_s) begin
      if (instret_r != CNT_MAX) begin
        instret_r <= instret_r + COUNTER_WIDTH'(1);
      end
      if (match_s) begin
        stamp_r <= cycle_count;
        done_r  <= 1'b1;
      end
    end
  end

  assign match   = match_s;
  assign done    = done_r;
  assign stamp   = stamp_r;
  assign instret = instret_r;

endmodule

// File: rtl/run_monitor.sv
// End-of-run monitor: counts run cycles, tracks each core's stop address,
// enforces an optional watchdog and streams one report record per core.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int NUM_CORES     = 2,
  parameter int ADDRESS_BITS  = 12,
  parameter int COUNTER_WIDTH = 32,
  parameter int CORE_ID_BITS  = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [ADDRESS_BITS-1:0]           stop_addr,
  input  logic [COUNTER_WIDTH-1:0]          timeout_limit,
  input  logic [NUM_CORES*ADDRESS_BITS-1:0] pc_memory1,
  input  logic [NUM_CORES-1:0]              pc_valid,
  output logic [NUM_CORES-1:0]              core_done,
  output logic                              running,
  output logic                              all_done,
  output logic                              timed_out,
  output logic [COUNTER_WIDTH-1:0]          cycle_count,
  output logic                              report_valid,
  input  logic                              report_ready,
  output logic [CORE_ID_BITS-1:0]           report_core,
  output logic                              report_done,
  output logic [COUNTER_WIDTH-1:0]          report_cycles,
  output logic [COUNTER_WIDTH-1:0]          report_instret
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = COUNTER_MAX[COUNTER_WIDTH-1:0];
  localparam logic [CORE_ID_BITS-1:0]  LAST_IDX = CORE_ID_BITS'(NUM_CORES - 1);

  state_e                   state_r;
  state_e                   state_next_s;
  logic [COUNTER_WIDTH-1:0] cycle_count_r;
  logic [COUNTER_WIDTH-1:0] timeout_r;
  logic [ADDRESS_BITS-1:0]  stop_addr_r;
  logic                     all_done_r;
  logic                     timed_out_r;
  logic                     running_r;
  logic                     report_valid_r;
  logic [CORE_ID_BITS-1:0]  idx_r;

  logic                     run_s;
  logic                     arm_s;
  logic                     all_next_s;
  logic                     expire_s;
  logic                     accept_s;
  logic                     last_s;
  logic                     sel_s;
  logic                     unused_rec_s;
  logic [NUM_CORES-1:0]     match_s;
  logic [NUM_CORES-1:0]     done_s;
  logic [COUNTER_WIDTH-1:0] stamp_s   [NUM_CORES];
  logic [COUNTER_WIDTH-1:0] instret_s [NUM_CORES];
  report_rec_t              rec_s;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    run_monitor_core_tracker #(
      .ADDRESS_BITS (ADDRESS_BITS),
      .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_tracker (
      .clock      (clock),
      .reset      (reset),
      .clear      (arm_s),
      .enable     (run_s),
      .pc         (pc_memory1[g*ADDRESS_BITS +: ADDRESS_BITS]),
      .pc_valid   (pc_valid[g]),
      .stop_addr  (stop_addr_r),
      .cycle_count(cycle_count_r),
      .match      (match_s[g]),
      .done       (done_s[g]),
      .stamp      (stamp_s[g]),
      .instret    (instret_s[g])
    );
  end

  // Next-state logic; completion takes priority over a simultaneous watchdog expiry.
  always_comb begin
    state_next_s = state_r;
    run_s        = (state_r == RUN);
    arm_s        = 1'b0;
    accept_s     = report_valid_r & report_ready;
    last_s       = (idx_r == LAST_IDX);
    all_next_s   = &(done_s | match_s);
    expire_s     = (timeout_r != '0) && (cycle_count_r == timeout_r - COUNTER_WIDTH'(1));
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          arm_s        = 1'b1;
          state_next_s = RUN;
        end else begin
          state_next_s = state_r;
        end
      end
      RUN: begin
        if (all_next_s || expire_s) begin
          state_next_s = REPORT;
        end else begin
          state_next_s = RUN;
        end
      end
      REPORT: begin
        if (accept_s && last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = REPORT;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Control registers, run counter and report index.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r        <= IDLE;
      cycle_count_r  <= '0;
      timeout_r      <= '0;
      stop_addr_r    <= '0;
      all_done_r     <= 1'b0;
      timed_out_r    <= 1'b0;
      running_r      <= 1'b0;
      report_valid_r <= 1'b0;
      idx_r          <= '0;
    end else begin
      state_r        <= state_next_s;
      running_r      <= (state_next_s == RUN);
      report_valid_r <= (state_next_s == REPORT);
      if (arm_s) begin
        cycle_count_r <= '0;
        timeout_r     <= timeout_limit;
        stop_addr_r   <= stop_addr;
        all_done_r    <= 1'b0;
        timed_out_r   <= 1'b0;
        idx_r         <= '0;
      end else if (run_s) begin
        if (cycle_count_r != CNT_MAX) begin
          cycle_count_r <= cycle_count_r + COUNTER_WIDTH'(1);
        end
        if (all_next_s) begin
          all_done_r <= 1'b1;
        end else if (expire_s) begin
          timed_out_r <= 1'b1;
        end
      end else if (accept_s) begin
        idx_r <= last_s ? '0 : idx_r + CORE_ID_BITS'(1);
      end
    end
  end

  // Record mux: OR of one-hot selected cores, all-zero whenever no record is offered.
  always_comb begin
    rec_s      = '0;
    sel_s      = 1'b0;
    rec_s.core = report_valid_r ? REC_ID_W'(idx_r) : '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      sel_s         = report_valid_r && (idx_r == CORE_ID_BITS'(i));
      rec_s.done    = rec_s.done | (sel_s & done_s[i]);
      rec_s.cycles  = rec_s.cycles | ({REC_CNT_W{sel_s}} &
                      (done_s[i] ? REC_CNT_W'(stamp_s[i]) : COUNTER_MAX));
      rec_s.instret = rec_s.instret | ({REC_CNT_W{sel_s}} & REC_CNT_W'(instret_s[i]));
    end
  end

  assign unused_rec_s   = ^rec_s;
  assign core_done      = done_s;
  assign running        = running_r;
  assign all_done       = all_done_r;
  assign timed_out      = timed_out_r;
  assign cycle_count    = cycle_count_r;
  assign report_valid   = report_valid_r;
  assign report_core    = rec_s.core[CORE_ID_BITS-1:0];
  assign report_done    = rec_s.done;
  assign report_cycles  = rec_s.cycles[COUNTER_WIDTH-1:0];
  assign report_instret = rec_s.instret[COUNTER_WIDTH-1:0];

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor (2 cores): expected report records are queued at
// run start and popped as the monitor offers them.
module tb_run_monitor;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] stop_addr;
  logic [31:0] timeout_limit;
  logic [23:0] pc_memory1;
  logic [1:0]  pc_valid;
  logic [1:0]  core_done;
  logic        running;
  logic        all_done;
  logic        timed_out;
  logic [31:0] cycle_count;
  logic        report_valid;
  logic        report_ready;
  logic [3:0]  report_core;
  logic        report_done;
  logic [31:0] report_cycles;
  logic [31:0] report_instret;

  typedef struct packed {
    logic [3:0]  core;
    logic        done;
    logic [31:0] cycles;
    logic [31:0] instret;
  } rec_t;

  rec_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  run_monitor #(
    .NUM_CORES(2), .ADDRESS_BITS(12), .COUNTER_WIDTH(32), .CORE_ID_BITS(4)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .stop_addr(stop_addr),
    .timeout_limit(timeout_limit), .pc_memory1(pc_memory1), .pc_valid(pc_valid),
    .core_done(core_done), .running(running), .all_done(all_done),
    .timed_out(timed_out), .cycle_count(cycle_count), .report_valid(report_valid),
    .report_ready(report_ready), .report_core(report_core), .report_done(report_done),
    .report_cycles(report_cycles), .report_instret(report_instret)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_rec(input logic [3:0] core, input logic done,
                          input logic [31:0] cycles, input logic [31:0] instret);
    rec_t r;
    r.core = core; r.done = done; r.cycles = cycles; r.instret = instret;
    sb_q.push_back(r);
  endtask

  task automatic check_status(input string tag, input logic [1:0] cd, input logic run,
                              input logic ad, input logic to, input logic [31:0] cc);
    check({tag, "_core_done"}, core_done, cd);
    check({tag, "_running"}, running, run);
    check({tag, "_all_done"}, all_done, ad);
    check({tag, "_timed_out"}, timed_out, to);
    check({tag, "_cycle_count"}, cycle_count, cc);
  endtask

  task automatic check_zero(input string tag);
    check_status(tag, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0);
    check({tag, "_report_valid"}, report_valid, 1'b0);
    check({tag, "_report_fields"}, {report_core, report_done, report_cycles, report_instret}, 64'd0);
    check({tag, "_report_instret"}, report_instret, 32'd0);
  endtask

  task automatic arm(input logic [11:0] addr, input logic [31:0] limit);
    start = 1'b1; stop_addr = addr; timeout_limit = limit;
    tick();
    start = 1'b0;
    check_status("armed", 2'b00, 1'b1, 1'b0, 1'b0, 32'd0);
  endtask

  // Drive n RUN cycles; hit<0 means the core never reaches 0x0B0. Core 0 may bubble.
  task automatic run_cycles(input int n, input int hit0, input int hit1,
                            input int bub_lo, input int bub_hi, input int glitch);
    int hit;
    int pcv;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 2; i++) begin
        hit = (i == 0) ? hit0 : hit1;
        if (i == 0 && c >= bub_lo && c <= bub_hi) begin
          pc_valid[i] = 1'b0;
          pcv = 32'h0B0;
        end else begin
          pc_valid[i] = 1'b1;
          pcv = (hit >= 0) ? 32'h0B0 - 4 * (hit - c) : 32'h400 + 4 * c;
        end
        pc_memory1[i*12 +: 12] = 12'(pcv);
      end
      start     = (c == glitch);
      stop_addr = (c == glitch) ? 12'h000 : 12'h0B0;
      tick();
    end
    start     = 1'b0;
    pc_valid  = 2'b00;
    stop_addr = 12'h0B0;
  endtask

  // mode 0: ready held high; mode 1: low for 5 cycles then toggling.
  task automatic collect(input int n, input int mode);
    int got = 0;
    int k = 0;
    while (got < n && k < 200) begin
      report_ready = (mode == 0) ? 1'b1 : ((k < 5) ? 1'b0 : 1'(k % 2));
      if (report_valid) begin
        if (sb_q.size() > 0) begin
          check("rec_core", report_core, sb_q[0].core);
          check("rec_done", report_done, sb_q[0].done);
          check("rec_cycles", report_cycles, sb_q[0].cycles);
          check("rec_instret", report_instret, sb_q[0].instret);
          if (report_ready) begin
            void'(sb_q.pop_front());
            got++;
          end
        end else begin
          check("rec_unexpected_valid", report_valid, 1'b0);
        end
      end
      tick();
      k++;
    end
    report_ready = 1'b0;
    check("records_accepted", got, n);
    check("valid_after_report", report_valid, 1'b0);
    check("running_after_report", running, 1'b0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop_addr = 12'h0B0; timeout_limit = 32'd0;
    pc_memory1 = 24'd0; pc_valid = 2'b00; report_ready = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    reset = 1'b1;
    tick();
    check_zero("idle");

    // Both cores stop, watchdog off.
    push_rec(4'd0, 1'b1, 32'd44, 32'd45);
    push_rec(4'd1, 1'b1, 32'd60, 32'd61);
    arm(12'h0B0, 32'd0);
    run_cycles(61, 44, 60, -1, -1, -1);
    check_status("t1_end", 2'b11, 1'b0, 1'b1, 1'b0, 32'd61);
    check("t1_report_valid", report_valid, 1'b1);
    collect(2, 0);
    check("t1_done_hold_cycles", cycle_count, 32'd61);

    // Watchdog expiry; start from DONE re-arms with cleared state.
    push_rec(4'd0, 1'b1, 32'd44, 32'd45);
    push_rec(4'd1, 1'b0, 32'hFFFF_FFFF, 32'd100);
    arm(12'h0B0, 32'd100);
    run_cycles(100, 44, -1, -1, -1, -1);
    check_status("t2_end", 2'b01, 1'b0, 1'b0, 1'b1, 32'd100);
    collect(2, 0);

    // Last core matches in the expiry cycle: completion wins.
    push_rec(4'd0, 1'b1, 32'd44, 32'd45);
    push_rec(4'd1, 1'b1, 32'd60, 32'd61);
    arm(12'h0B0, 32'd61);
    run_cycles(61, 44, 60, -1, -1, -1);
    check_status("t3_end", 2'b11, 1'b0, 1'b1, 1'b0, 32'd61);
    collect(2, 0);

    // Core 0 bubbles for 10 cycles with a stale stop PC.
    push_rec(4'd0, 1'b1, 32'd44, 32'd35);
    push_rec(4'd1, 1'b1, 32'd60, 32'd61);
    arm(12'h0B0, 32'd0);
    run_cycles(61, 44, 60, 10, 19, -1);
    check_status("t4_end", 2'b11, 1'b0, 1'b1, 1'b0, 32'd61);
    collect(2, 0);

    // Start pulse during RUN is ignored; report under backpressure.
    push_rec(4'd0, 1'b1, 32'd44, 32'd45);
    push_rec(4'd1, 1'b1, 32'd60, 32'd61);
    arm(12'h0B0, 32'd0);
    run_cycles(61, 44, 60, -1, -1, 20);
    check_status("t5_end", 2'b11, 1'b0, 1'b1, 1'b0, 32'd61);
    collect(2, 1);

    // Reset in the middle of REPORT discards the stream.
    arm(12'h0B0, 32'd0);
    run_cycles(61, 44, 60, -1, -1, -1);
    report_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("t6_hold_valid", report_valid, 1'b1);
      check("t6_hold_core", report_core, 4'd0);
      check("t6_hold_cycles", report_cycles, 32'd44);
      tick();
    end
    reset = 1'b0;
    tick();
    check_zero("t6_reset");
    reset = 1'b1;
    tick();
    check_zero("t6_idle");

    // Fresh run from IDLE after the abort.
    push_rec(4'd0, 1'b1, 32'd44, 32'd45);
    push_rec(4'd1, 1'b1, 32'd60, 32'd61);
    arm(12'h0B0, 32'd0);
    run_cycles(61, 44, 60, -1, -1, -1);
    check_status("t7_end", 2'b11, 1'b0, 1'b1, 1'b0, 32'd61);
    collect(2, 0);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/run_monitor.md
Name: run_monitor

Overview:
Synthesizable, parametrised end-of-run monitor for single- and multi-core BRISC-V builds. It replaces bench-only stop-address snooping and cycle counting.
- Per core: watches the memory1-stage PC and counts retired instructions.
- Per core: timestamps the cycle at which the core reaches a programmable stop address.
- Global: enforces an optional timeout watchdog.
- After the run: streams one report record per core over a valid/ready handshake, for a UART or debug bridge.

Parameters:
NUM_CORES, 2, number of monitored cores (1..16)
ADDRESS_BITS, 12, PC width compared against stop_addr
COUNTER_WIDTH, 32, width of cycle, timestamp and instret counters
CORE_ID_BITS, 4, width of report_core (must satisfy 2**CORE_ID_BITS >= NUM_CORES)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (asserted when 0)
start  in  1  one-cycle pulse; arms a run in IDLE or DONE, ignored otherwise
stop_addr  in  ADDRESS_BITS  stop PC, sampled on accepted start
timeout_limit  in  COUNTER_WIDTH  watchdog limit, sampled on accepted start; 0 disables watchdog
pc_memory1  in  NUM_CORES*ADDRESS_BITS  packed memory1-stage PCs, core i at [i*ADDRESS_BITS +: ADDRESS_BITS]
pc_valid  in  NUM_CORES  core i memory1 stage holds a real (non-bubble) instruction
core_done  out  NUM_CORES  core i has reached stop_addr in this run
running  out  1  state == RUN
all_done  out  1  every core reached stop_addr (sticky until next start or reset)
timed_out  out  1  watchdog expired before all_done (sticky)
cycle_count  out  COUNTER_WIDTH  cycles elapsed in current or last run
report_valid  out  1  report record available
report_ready  in  1  consumer accepts record when valid & ready
report_core  out  CORE_ID_BITS  core index of record
report_done  out  1  core reached stop_addr
report_cycles  out  COUNTER_WIDTH  stop timestamp; all-ones if not done
report_instret  out  COUNTER_WIDTH  retired instruction count

Behaviour:
- Reset (reset==0 at posedge) forces the following; all other outputs are 0:
  - state=IDLE
  - counters, stamps, core_done, all_done, timed_out = 0
  - report_valid=0
- FSM states: IDLE, RUN, REPORT, DONE.
- IDLE/DONE + start:
  - Clear counters, stamps, core_done, all_done and timed_out.
  - Latch stop_addr and timeout_limit.
  - Next state RUN; cycle_count=0 in the first RUN cycle.
- RUN:
  - cycle_count increments by 1 every cycle, saturating at all-ones.
  - start is ignored.
- Per core i in RUN, while core_done[i]==0:
  - pc_valid[i]==1 increments instret[i] (saturating), including the stop instruction itself.
  - pc_valid[i] & PC_i==stop_addr: stamp[i]=current cycle_count; core_done[i]=1 next cycle.
  - After core_done[i] is set, instret[i] and stamp[i] are frozen.
- Completion: in the cycle the last outstanding core matches:
  - all_done=1 next cycle; RUN->REPORT on the same edge.
  - cycle_count freezes at its value+1 from that edge on.
- Watchdog:
  - If timeout_limit!=0 and cycle_count==timeout_limit-1 with cores still outstanding, then timed_out=1 next cycle and RUN->REPORT.
  - If the last core completes in the same cycle as expiry, completion wins: all_done=1, timed_out=0.
- REPORT:
  - Internal index starts at 0 and report_valid=1 from the first REPORT cycle.
  - Record fields stay stable while valid & !ready.
  - On valid & ready, index increments.
  - After core NUM_CORES-1 is accepted: report_valid=0 next cycle, state->DONE.
  - Unfinished cores report report_done=0 and report_cycles=all-ones.
- DONE: all outputs hold; start re-arms exactly as from IDLE.
- Reset mid-RUN or mid-REPORT aborts immediately to reset values; a partially streamed report is discarded.
- NUM_CORES==1 is legal: a single report record.

Decomposition:
- Package run_monitor_pkg holds:
  - the state enum (IDLE, RUN, REPORT, DONE);
  - a report record struct {core, done, cycles, instret};
  - the constant COUNTER_MAX = all-ones.
- Sub-module run_monitor_core_tracker, instantiated NUM_CORES times. Per core it does the stop compare, done flag, stamp register and saturating instret counter; inputs are clear, enable, pc, pc_valid, stop_addr and cycle_count.

Test Plan:
1. NUM_CORES=2, stop_addr=0x0B0, timeout 0.
   - Stimulus: core0 valid PCs 0x000,0x004,... reaching 0x0B0 at cycle 44; core1 reaches 0x0B0 at cycle 60.
   - Response: stamps 44/60, instret 45/61, all_done at cycle 61, two records streamed with report_ready tied 1.
2. Timeout 100; core1 never reaches stop.
   - Response: timed_out=1, all_done=0, cycle_count=100, core1 record has done=0, cycles=0xFFFFFFFF.
3. Last core matches in the same cycle the watchdog expires (limit 61, match at cycle 60).
   - Response: all_done=1, timed_out=0.
4. Bubbles: core0 has pc_valid=0 for 10 cycles with stale PC 0x0B0.
   - Response: no match and no instret increment during the bubbles.
5. Backpressure: report_ready low for 5 cycles, then toggling.
   - Response: record 0 held stable; each record accepted exactly once, in order 0,1.
6. Control events:
   - Reset low mid-REPORT: all outputs return to 0.
   - Start in DONE: new run with cleared counters.
   - Start during RUN: ignored.
